// File: rtl/led_chase_scorer.sv
// LED-chase reaction game: one lit LED steps across the bar in wrap or ping-pong
// mode, and each key press scores against the bonus/hit masks with a saturating total.
module led_chase_scorer #(
    parameter int N_LED       = 18,
    parameter int SCORE_W     = 10,
    parameter int SCORE_MAX   = 1000,
    parameter int BONUS_PTS   = 10,
    parameter int HIT_PTS     = 7,
    parameter int MISS_PTS    = 5,
    parameter int DIV0        = 2500000,
    parameter int DIV1        = 5000000,
    parameter int DIV2        = 10000000,
    parameter int DIV3        = 50000000,
    parameter int ROUND_STEPS = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_n,
    input  logic               start,
    input  logic [1:0]         speed_sel,
    input  logic               mode,
    input  logic [N_LED-1:0]   bonus_mask,
    input  logic [N_LED-1:0]   hit_mask,
    output logic [N_LED-1:0]   led,
    output logic [SCORE_W-1:0] score,
    output logic [15:0]        score_bcd,
    output logic [1:0]         game_state,
    output logic               hit_pulse,
    output logic               miss_pulse
);
    localparam int DIV_A   = (DIV0 > DIV1) ? DIV0 : DIV1;
    localparam int DIV_B   = (DIV2 > DIV3) ? DIV2 : DIV3;
    localparam int DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
    localparam int TMR_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int STEP_W  = (ROUND_STEPS > 2) ? $clog2(ROUND_STEPS) : 1;
    localparam int SW1     = SCORE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                key_q;
    logic [1:0]          speed_q;
    logic                dir_up;
    logic [TMR_W-1:0]    timer;
    logic [STEP_W-1:0]   step_cnt;
    logic [TMR_W-1:0]    div_last;
    logic                press, speed_chg, step, last_step;
    logic                on_bonus, on_hit;
    logic [N_LED-1:0]    led_next;
    logic                dir_next;
    logic [SW1-1:0]      sum_bonus, sum_hit;
    logic [SCORE_W-1:0]  score_next;
    logic [13:0]         score_v;

    always_comb begin
        div_last = TMR_W'(DIV0 - 1);
        case (speed_sel)
            2'd1:    div_last = TMR_W'(DIV1 - 1);
            2'd2:    div_last = TMR_W'(DIV2 - 1);
            2'd3:    div_last = TMR_W'(DIV3 - 1);
            default: div_last = TMR_W'(DIV0 - 1);
        endcase
    end

    assign press     = key_q & ~key_n;
    assign speed_chg = (speed_sel != speed_q);
    assign step      = (state_q == S_RUN) && !start && !speed_chg && (timer == div_last);
    assign last_step = (ROUND_STEPS != 0) && (int'(step_cnt) == ROUND_STEPS - 1);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_OVER: if (start) state_d = S_RUN;
            S_RUN: begin
                if (start)                  state_d = S_RUN;
                else if (step && last_step) state_d = S_OVER;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign game_state = state_q;

    // Ping-pong reverses on the end LED itself so each end is lit for only one step.
    always_comb begin
        led_next = led;
        dir_next = dir_up;
        if (mode) begin
            if (dir_up && led[N_LED-1]) begin
                dir_next = 1'b0;
                led_next = led >> 1;
            end else if (!dir_up && led[0]) begin
                dir_next = 1'b1;
                led_next = led << 1;
            end else if (dir_up) begin
                led_next = led << 1;
            end else begin
                led_next = led >> 1;
            end
        end else if (dir_up) begin
            led_next = {led[N_LED-2:0], led[N_LED-1]};
        end else begin
            led_next = {led[0], led[N_LED-1:1]};
        end
    end

    assign on_bonus = |(led & bonus_mask);
    assign on_hit   = |(led & hit_mask);

    always_comb begin
        sum_bonus = {1'b0, score} + SW1'(BONUS_PTS);
        sum_hit   = {1'b0, score} + SW1'(HIT_PTS);
        if (on_bonus)
            score_next = (sum_bonus > SW1'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_bonus[SCORE_W-1:0];
        else if (on_hit)
            score_next = (sum_hit > SW1'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_hit[SCORE_W-1:0];
        else
            score_next = (score < SCORE_W'(MISS_PTS)) ? '0 : score - SCORE_W'(MISS_PTS);
    end

    assign score_v = 14'(score);

    always_ff @(posedge clk) begin
        if (!reset) begin
            key_q      <= 1'b1;
            speed_q    <= 2'd0;
            led        <= N_LED'(1);
            dir_up     <= 1'b1;
            timer      <= '0;
            step_cnt   <= '0;
            score      <= '0;
            score_bcd  <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            key_q      <= key_n;
            speed_q    <= speed_sel;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            score_bcd  <= {4'(score_v / 14'd1000),
                           4'((score_v / 14'd100) % 14'd10),
                           4'((score_v / 14'd10) % 14'd10),
                           4'(score_v % 14'd10)};
            if (start) begin
                score    <= '0;
                led      <= N_LED'(1);
                dir_up   <= 1'b1;
                timer    <= '0;
                step_cnt <= '0;
            end else if (state_q == S_RUN) begin
                // Scoring sees the pre-step LED; a coincident step still happens.
                if (press) begin
                    score      <= score_next;
                    hit_pulse  <= on_bonus | on_hit;
                    miss_pulse <= ~(on_bonus | on_hit);
                end
                if (speed_chg) begin
                    timer <= '0;
                end else if (step) begin
                    timer    <= '0;
                    led      <= led_next;
                    dir_up   <= dir_next;
                    step_cnt <= step_cnt + STEP_W'(1);
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_chase_scorer.sv
// Bench for led_chase_scorer: an unlimited-round and a 5-step-round instance share
// stimulus and are compared every cycle against position/score models.
module tb_led_chase_scorer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_n = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [1:0] speed_sel = 2'd0;
    logic [7:0] bonus_mask = 8'h00;
    logic [7:0] hit_mask = 8'h00;

    logic [7:0]  led_a, led_b;
    logic [9:0]  score_a, score_b;
    logic [15:0] bcd_a, bcd_b;
    logic [1:0]  gs_a, gs_b;
    logic        hp_a, hp_b, mp_a, mp_b;

    int total = 0;
    int bad = 0;

    typedef struct {
        int st; int pos; int dir; int tmr; int steps; int score; int bcd;
        bit hit; bit miss; bit key_q; int spd_q;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    led_chase_scorer #(.N_LED(8), .SCORE_W(10), .SCORE_MAX(1000), .BONUS_PTS(10), .HIT_PTS(7),
        .MISS_PTS(5), .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10), .ROUND_STEPS(0)) dut_a (
        .clk(clk), .reset(reset), .key_n(key_n), .start(start), .speed_sel(speed_sel),
        .mode(mode), .bonus_mask(bonus_mask), .hit_mask(hit_mask), .led(led_a),
        .score(score_a), .score_bcd(bcd_a), .game_state(gs_a), .hit_pulse(hp_a),
        .miss_pulse(mp_a));

    led_chase_scorer #(.N_LED(8), .SCORE_W(10), .SCORE_MAX(1000), .BONUS_PTS(10), .HIT_PTS(7),
        .MISS_PTS(5), .DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10), .ROUND_STEPS(5)) dut_b (
        .clk(clk), .reset(reset), .key_n(key_n), .start(start), .speed_sel(speed_sel),
        .mode(mode), .bonus_mask(bonus_mask), .hit_mask(hit_mask), .led(led_b),
        .score(score_b), .score_bcd(bcd_b), .game_state(gs_b), .hit_pulse(hp_b),
        .miss_pulse(mp_b));

    function automatic int bcd_of(int v);
        int r = 0;
        for (int d = 0; d < 4; d++) begin
            r = r | ((v % 10) << (4 * d));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n.st = 0; n.pos = 0; n.dir = 1; n.tmr = 0; n.steps = 0; n.score = 0; n.bcd = 0;
        n.hit = 0; n.miss = 0; n.key_q = 1; n.spd_q = 0;
        return n;
    endfunction

    function automatic int clocks_per_step(int s);
        case (s)
            1: return 6;
            2: return 8;
            3: return 10;
            default: return 4;
        endcase
    endfunction

    // One clock of the game as the rules describe it: position/direction as integers.
    function automatic mdl_t mstep(mdl_t m, int round_len, bit rst_n, bit k, bit st, int spd,
                                   bit md, int bm, int hm);
        mdl_t n = m;
        bit pressed;
        if (!rst_n) return mreset();
        pressed = m.key_q && !k;
        n.key_q = k;
        n.spd_q = spd;
        n.hit = 0;
        n.miss = 0;
        n.bcd = bcd_of(m.score);
        if (st) begin
            n.st = 1; n.score = 0; n.pos = 0; n.dir = 1; n.tmr = 0; n.steps = 0;
            return n;
        end
        if (m.st == 1) begin
            if (pressed) begin
                if ((bm >> m.pos) & 1) begin
                    n.score = (m.score + 10 > 1000) ? 1000 : m.score + 10;
                    n.hit = 1;
                end else if ((hm >> m.pos) & 1) begin
                    n.score = (m.score + 7 > 1000) ? 1000 : m.score + 7;
                    n.hit = 1;
                end else begin
                    n.score = (m.score < 5) ? 0 : m.score - 5;
                    n.miss = 1;
                end
            end
            if (spd != m.spd_q) begin
                n.tmr = 0;
            end else if (m.tmr == clocks_per_step(spd) - 1) begin
                n.tmr = 0;
                if (md) begin
                    if (m.dir > 0 && m.pos == 7) n.dir = -1;
                    else if (m.dir < 0 && m.pos == 0) n.dir = 1;
                    n.pos = m.pos + n.dir;
                end else begin
                    n.pos = (m.dir > 0) ? (m.pos + 1) % 8 : (m.pos + 7) % 8;
                end
                n.steps = m.steps + 1;
                if (round_len != 0 && n.steps == round_len) n.st = 2;
            end else begin
                n.tmr = m.tmr + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("led_a",   32'(led_a),   32'(1 << ma.pos));
        chk("score_a", 32'(score_a), 32'(ma.score));
        chk("bcd_a",   32'(bcd_a),   32'(ma.bcd));
        chk("state_a", 32'(gs_a),    32'(ma.st));
        chk("hit_a",   32'(hp_a),    32'(ma.hit));
        chk("miss_a",  32'(mp_a),    32'(ma.miss));
        chk("led_b",   32'(led_b),   32'(1 << mb.pos));
        chk("score_b", 32'(score_b), 32'(mb.score));
        chk("state_b", 32'(gs_b),    32'(mb.st));
        chk("pulse_b", 32'({hp_b, mp_b}), 32'({mb.hit, mb.miss}));
    endtask

    task automatic tick();
        @(posedge clk);
        ma = mstep(ma, 0, reset, key_n, start, int'(speed_sel), mode, int'(bonus_mask), int'(hit_mask));
        mb = mstep(mb, 5, reset, key_n, start, int'(speed_sel), mode, int'(bonus_mask), int'(hit_mask));
        @(negedge clk);
        check_all();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press();
        key_n = 1'b0;
        tick();
        key_n = 1'b1;
        tick();
    endtask

    task automatic wait_pos(int p);
        for (int i = 0; i < 200 && ma.pos != p; i++) tick();
        chk("wait_pos", 32'(ma.pos), 32'(p));
    endtask

    task automatic wait_step_from(int p);
        for (int i = 0; i < 200 && !(ma.pos == p && ma.tmr == 3); i++) tick();
        chk("wait_step", 32'(ma.pos * 16 + ma.tmr), 32'(p * 16 + 3));
    endtask

    initial begin
        ma = mreset();
        mb = mreset();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_led", 32'(led_a), 32'h01);
        chk("rst_state", 32'(gs_a), 32'h0);
        reset = 1'b1;
        repeat (6) tick();

        // wrap chase, then ping-pong, then a speed change mid-run
        pulse_start();
        repeat (40) tick();
        mode = 1'b1;
        repeat (70) tick();
        speed_sel = 2'd2;
        repeat (20) tick();
        speed_sel = 2'd3;
        repeat (25) tick();
        speed_sel = 2'd0;
        mode = 1'b0;

        // basic scoring, misses to floor, held key
        bonus_mask = 8'h08;
        hit_mask = 8'h18;
        pulse_start();
        wait_pos(3); press();
        chk("bonus10", 32'(score_a), 32'd10);
        wait_pos(4); press();
        chk("hit17", 32'(score_a), 32'd17);
        wait_pos(0); press();
        chk("miss12", 32'(score_a), 32'd12);
        press(); press(); press();
        chk("floor0", 32'(score_a), 32'd0);
        key_n = 1'b0;
        repeat (8) tick();
        key_n = 1'b1;
        tick();

        // saturation
        pulse_start();
        bonus_mask = 8'hFF;
        hit_mask = 8'h00;
        repeat (96) press();
        bonus_mask = 8'h00;
        hit_mask = 8'hFF;
        repeat (5) press();
        chk("preload", 32'(score_a), 32'd995);
        bonus_mask = 8'hFF;
        press();
        chk("sat_bonus", 32'(score_a), 32'd1000);
        bonus_mask = 8'h00;
        press();
        chk("sat_hit", 32'(score_a), 32'd1000);
        chk("bcd_sat", 32'(bcd_a), 32'h1000);

        // press coincident with a step
        hit_mask = 8'h04;
        pulse_start();
        wait_step_from(2);
        key_n = 1'b0;
        tick();
        chk("coinc_score", 32'(score_a), 32'd7);
        chk("coinc_led", 32'(led_a), 32'h08);
        key_n = 1'b1;
        tick();

        // round end on the 5-step instance
        pulse_start();
        repeat (20) tick();
        chk("over_state", 32'(gs_b), 32'h2);
        chk("over_led", 32'(led_b), 32'h20);
        press();
        chk("over_score", 32'(score_b), 32'd0);
        repeat (6) tick();
        chk("over_frozen", 32'(led_b), 32'h20);
        pulse_start();
        chk("restart_state", 32'(gs_b), 32'h1);
        chk("restart_led", 32'(led_b), 32'h01);

        // reset mid-run
        hit_mask = 8'hFF;
        repeat (5) tick();
        press();
        reset = 1'b0;
        tick();
        chk("midrst_state", 32'(gs_a), 32'h0);
        chk("midrst_score", 32'(score_a), 32'd0);
        reset = 1'b1;
        tick();

        // randomized play
        for (int i = 0; i < 900; i++) begin
            key_n = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 59) == 0);
            reset = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0) mode = ~mode;
            if ($urandom_range(0, 29) == 0) begin
                bonus_mask = 8'($urandom);
                hit_mask = 8'($urandom);
            end
            if (i % 150 == 0) start = 1'b1;
            tick();
        end
        reset = 1'b1;
        start = 1'b0;
        key_n = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
